fft_stage_sequencer: RTL and testbench



---
 rtl/fft_stage_sequencer.sv | 155 +++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Control sequencer for the 16-point radix-2 in-place FFT core. On start it
// walks stage 0..3 and butterfly 0..7, issuing one read per cycle, then
// drains the butterfly pipeline before the next stage so stage s+1 never
// reads a location before stage s has written it. The issued indices are
// delayed by BF_LATENCY so a second lookup can regenerate write addresses.
//
// Optional feature: define FFT_STAGE_SEQ_STALL_EN to add the `stall` input,
// which freezes all sequencing state and suppresses rd_en/wr_en.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous, active-high reset
//   start        one-cycle request to run a full transform
//   stall        (FFT_STAGE_SEQ_STALL_EN only) freeze sequencing
//   busy         high from first issue cycle through final drain cycle
//   done         one-cycle pulse after the last write of stage 3
//   stage        read stage index to the read-address lookup
//   butterfly    read butterfly index to the read-address lookup
//   rd_en        sample-memory read strobe
//   wr_en        sample-memory write strobe
//   wr_stage     stage index delayed by BF_LATENCY
//   wr_butterfly butterfly index delayed by BF_LATENCY
module fft_stage_sequencer #(
  parameter int unsigned BF_LATENCY = 3  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef FFT_STAGE_SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic [1:0] stage,
  output logic [2:0] butterfly,
  output logic       rd_en,
  output logic       wr_en,
  output logic [1:0] wr_stage,
  output logic [2:0] wr_butterfly
);

  localparam int unsigned N_STAGES = 4;
  localparam int unsigned N_BF     = 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] bf_q, bf_d;
  logic [3:0] drain_q, drain_d;

  // Write delay line: entry 0 is the newest, entry BF_LATENCY-1 is the tail.
  logic [BF_LATENCY-1:0] vld_q;
  logic [1:0]            dst_q [BF_LATENCY];
  logic [2:0]            dbf_q [BF_LATENCY];

  logic hold;
  logic issue;

`ifdef FFT_STAGE_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign issue = (state_q == StIssue);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          stage_d = 2'd0;
          bf_d    = 3'd0;
        end
      end
      StIssue: begin
        // Butterfly stays at 7 through the drain; it only wraps on stage advance.
        if (bf_q == 3'(N_BF - 1)) begin
          state_d = StDrain;
          drain_d = 4'd0;
        end else begin
          bf_d = bf_q + 3'd1;
        end
      end
      StDrain: begin
        if (drain_q == 4'(BF_LATENCY - 1)) begin
          bf_d = 3'd0;
          if (stage_q == 2'(N_STAGES - 1)) begin
            state_d = StDone;
            stage_d = 2'd0;
          end else begin
            state_d = StIssue;
            stage_d = stage_q + 2'd1;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= 2'd0;
      bf_q    <= 3'd0;
      drain_q <= 4'd0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < BF_LATENCY; i++) begin
        dst_q[i] <= 2'd0;
        dbf_q[i] <= 3'd0;
      end
    end else if (!hold) begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      bf_q     <= bf_d;
      drain_q  <= drain_d;
      vld_q[0] <= issue;
      // Idle entries carry the last issued indices, so the tail holds the last
      // written address whenever wr_en is low.
      dst_q[0] <= issue ? stage_q : dst_q[0];
      dbf_q[0] <= issue ? bf_q : dbf_q[0];
      for (int unsigned i = 1; i < BF_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dst_q[i] <= dst_q[i-1];
        dbf_q[i] <= dbf_q[i-1];
      end
    end
  end

  assign busy         = (state_q == StIssue) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign stage        = stage_q;
  assign butterfly    = bf_q;
  assign rd_en        = issue & ~hold;
  assign wr_en        = vld_q[BF_LATENCY-1] & ~hold;
  assign wr_stage     = dst_q[BF_LATENCY-1];
  assign wr_butterfly = dbf_q[BF_LATENCY-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: instance 0 uses BF_LATENCY=3, instance 1 uses BF_LATENCY=1.
// Expected read/write/done/busy events come from the cycle formulas
// (stage s issues at s*(8+L)+1+b relative to the start cycle).
module tb_fft_stage_sequencer;

  typedef struct {
    int cyc;
    int st;
    int bf;
  } ev_t;

  typedef struct {
    int lo;
    int hi;
  } iv_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, stall0;

  logic       rd [2];
  logic       wr [2];
  logic       dn [2];
  logic       by [2];
  logic [1:0] st [2];
  logic [1:0] wst [2];
  logic [2:0] bfv [2];
  logic [2:0] wbf [2];

  ev_t rq [2][$];
  ev_t wq [2][$];
  int  dq [2][$];
  iv_t bq [2][$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_sequencer #(.BF_LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
`ifdef FFT_STAGE_SEQ_STALL_EN
    .stall(stall0),
`endif
    .busy(by[0]), .done(dn[0]), .stage(st[0]), .butterfly(bfv[0]),
    .rd_en(rd[0]), .wr_en(wr[0]), .wr_stage(wst[0]), .wr_butterfly(wbf[0])
  );

  fft_stage_sequencer #(.BF_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef FFT_STAGE_SEQ_STALL_EN
    .stall(1'b0),
`endif
    .busy(by[1]), .done(dn[1]), .stage(st[1]), .butterfly(bfv[1]),
    .rd_en(rd[1]), .wr_en(wr[1]), .wr_stage(wst[1]), .wr_butterfly(wbf[1])
  );

  function automatic void chk(input bit ok, input string msg);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s", msg);
  endfunction

  function automatic int shf(input int k, input int sa, input int sn);
    return (sa > 0 && k >= sa) ? k + sn : k;
  endfunction

  // Push the expected events of one run started (start sampled) in cycle b.
  // Events with nominal relative cycle above cut are dropped (reset mid-run);
  // a stall of sn cycles from relative cycle sa delays every later event.
  task automatic push_run(input int id, input int b, input int l, input int sa, input int sn,
                          input int cut);
    int per, r, w, d, hi;
    per = 8 + l;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) begin
        r = s * per + 1 + k;
        w = r + l;
        if (r <= cut) rq[id].push_back('{b + shf(r, sa, sn), s, k});
        if (w <= cut) wq[id].push_back('{b + shf(w, sa, sn), s, k});
      end
    end
    d = 4 * per + 1;
    if (d <= cut) dq[id].push_back(b + shf(d, sa, sn));
    hi = (4 * per < cut) ? 4 * per : cut;
    bq[id].push_back('{b + 1, b + shf(hi, sa, sn)});
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  ex, exb, exd;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        ex = (rq[d].size() > 0) && (rq[d][0].cyc == cyc);
        e  = ex ? rq[d][0] : '{cyc, 0, 0};
        if (rd[d] || ex) begin
          chk(rd[d] == ex && int'(st[d]) == e.st && int'(bfv[d]) == e.bf,
              $sformatf("read%0d cyc=%0d got rd_en=%0b stage=%0d bf=%0d want rd_en=%0b stage=%0d bf=%0d",
                        d, cyc, rd[d], st[d], bfv[d], ex, e.st, e.bf));
          if (ex) void'(rq[d].pop_front());
        end
        ex = (wq[d].size() > 0) && (wq[d][0].cyc == cyc);
        e  = ex ? wq[d][0] : '{cyc, 0, 0};
        if (wr[d] || ex) begin
          chk(wr[d] == ex && int'(wst[d]) == e.st && int'(wbf[d]) == e.bf,
              $sformatf("write%0d cyc=%0d got wr_en=%0b stage=%0d bf=%0d want wr_en=%0b stage=%0d bf=%0d",
                        d, cyc, wr[d], wst[d], wbf[d], ex, e.st, e.bf));
          if (ex) void'(wq[d].pop_front());
        end
        exd = (dq[d].size() > 0) && (dq[d][0] == cyc);
        chk(dn[d] == exd, $sformatf("done%0d cyc=%0d got %0b want %0b", d, cyc, dn[d], exd));
        if (exd) void'(dq[d].pop_front());
        exb = (bq[d].size() > 0) && (cyc >= bq[d][0].lo) && (cyc <= bq[d][0].hi);
        chk(by[d] == exb, $sformatf("busy%0d cyc=%0d got %0b want %0b", d, cyc, by[d], exb));
        if (bq[d].size() > 0 && cyc >= bq[d][0].hi) void'(bq[d].pop_front());
        if (!exb && !exd)
          chk(st[d] == 2'd0 && bfv[d] == 3'd0,
              $sformatf("idle_idx%0d cyc=%0d got stage=%0d bf=%0d want 0/0", d, cyc, st[d], bfv[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int x);
    while (cyc < x) tick();
  endtask

  int x, y;

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    stall0 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: the monitor checks strobes; write indices checked here.
    repeat (10) begin
      tick();
      chk(wst[0] == 2'd0 && wbf[0] == 3'd0,
          $sformatf("reset_wr_idx cyc=%0d got %0d/%0d want 0/0", cyc, wst[0], wbf[0]));
    end

    // Full run on both latencies, with stray starts at 5 and 45, restart at 46.
    x = cyc;
    start0 = 1'b1;
    start1 = 1'b1;
    push_run(0, x, 3, 0, 0, 1000);
    push_run(1, x, 1, 0, 0, 1000);
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    goto(x + 5);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    goto(x + 45);
    start0 = 1'b1;
    tick();
    push_run(0, x + 46, 3, 0, 0, 1000);
    tick();
    start0 = 1'b0;
    goto(x + 46 + 50);
    for (int d = 0; d < 2; d++)
      chk(wst[d] == 2'd3 && wbf[d] == 3'd7,
          $sformatf("wr_idx_hold%0d got %0d/%0d want 3/7", d, wst[d], wbf[d]));

    // Reset sampled at the end of relative cycle 19 (stage 1 butterfly 7).
    y = cyc;
    start0 = 1'b1;
    push_run(0, y, 3, 0, 0, 19);
    tick();
    start0 = 1'b0;
    goto(y + 19);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    goto(y + 21);
    chk(wst[0] == 2'd0 && wbf[0] == 3'd0 && !rd[0] && !wr[0] && !by[0] && !dn[0],
        $sformatf("post_reset got wr_idx=%0d/%0d rd=%0b wr=%0b busy=%0b done=%0b want all 0",
                  wst[0], wbf[0], rd[0], wr[0], by[0], dn[0]));
    goto(y + 45);

`ifdef FFT_STAGE_SEQ_STALL_EN
    // Stall during relative cycles 10..14 (stage-0 drain).
    x = cyc;
    start0 = 1'b1;
    push_run(0, x, 3, 10, 5, 1000);
    tick();
    start0 = 1'b0;
    goto(x + 10);
    stall0 = 1'b1;
    goto(x + 15);
    stall0 = 1'b0;
    goto(x + 60);
`endif

    goto(cyc + 5);
    for (int d = 0; d < 2; d++) begin
      chk(rq[d].size() == 0, $sformatf("reads_left%0d got %0d want 0", d, rq[d].size()));
      chk(wq[d].size() == 0, $sformatf("writes_left%0d got %0d want 0", d, wq[d].size()));
      chk(dq[d].size() == 0, $sformatf("dones_left%0d got %0d want 0", d, dq[d].size()));
    end
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
